// File: rtl/fetch_unit_rv32i.sv
// fetch_unit_rv32i
//
// Instruction fetch front end for an RV32I core. It drives the fetch PC into a
// ROM with a synchronous read, captures the returned word one cycle later, and
// queues {pc, instr} pairs in a small FIFO. Decode takes words from the FIFO
// over a valid/ready handshake. A redirect flushes everything that is queued
// or in flight and restarts fetch at the target. A misaligned target sets a
// sticky fault and halts the unit until reset.
//
// Ports
//   clock          system clock, all state changes on posedge
//   reset          synchronous, active-high
//   rom_addr       fetch address to the ROM (the fetch_pc register)
//   rom_data       ROM word, valid the cycle after its address was issued
//   redirect_valid one-cycle request to change flow
//   redirect_pc    redirect target
//   out_valid      FIFO head holds a valid instruction
//   out_ready      decode accepts the head this cycle
//   out_pc         PC of the head instruction
//   out_instr      head instruction word
//   fault          sticky misaligned-redirect flag
module fetch_unit_rv32i #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fault
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic          fault_q, fault_d;

    // Shift-register FIFO: entry 0 is always the head, so the outputs come
    // straight from registers and never from rom_data.
    logic [31:0]   buf_pc_q    [DEPTH];
    logic [31:0]   buf_pc_d    [DEPTH];
    logic [31:0]   buf_instr_q [DEPTH];
    logic [31:0]   buf_instr_d [DEPTH];

    logic          pop;
    logic          redir;
    logic          misaligned;
    logic          issue;
    logic          capture;
    logic [CW:0]   occ;
    logic [CW-1:0] wr_idx;

    assign out_valid  = (state_q == RUN) && (count_q != '0);
    assign pop        = out_valid && out_ready;
    assign redir      = redirect_valid && (state_q == RUN);
    assign misaligned = (redirect_pc[1:0] != 2'b00);

    // Occupancy after this cycle's pop, counting the word already in flight.
    // pop implies count_q >= 1, so this never underflows.
    assign occ     = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue   = (state_q == RUN) && !redir && (occ < (CW+1)'(DEPTH));
    assign capture = (state_q == RUN) && !redir && inflight_q;
    assign wr_idx  = count_q - CW'(pop);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        fault_d       = fault_q;
        buf_pc_d      = buf_pc_q;
        buf_instr_d   = buf_instr_q;

        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                buf_pc_d[i]    = buf_pc_q[i+1];
                buf_instr_d[i] = buf_instr_q[i+1];
            end
        end

        // The push slot is computed after the pop shift, so push and pop in
        // the same cycle leave the count unchanged.
        if (capture) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    buf_pc_d[i]    = inflight_pc_q;
                    buf_instr_d[i] = rom_data;
                end
            end
        end

        count_d = count_q - CW'(pop) + CW'(capture);

        if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
        end

        // Redirect: the pop above still counts, but every other queued word
        // and the word in flight are dropped.
        if (redir) begin
            count_d    = '0;
            inflight_d = 1'b0;
            fetch_pc_d = redirect_pc;
            if (misaligned) begin
                fault_d = 1'b1;
                state_d = HALT;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            fault_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc_q[i]    <= '0;
                buf_instr_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            fault_q       <= fault_d;
            buf_pc_q      <= buf_pc_d;
            buf_instr_q   <= buf_instr_d;
        end
    end

    assign rom_addr  = fetch_pc_q;
    assign out_pc    = buf_pc_q[0];
    assign out_instr = buf_instr_q[0];
    assign fault     = fault_q;

endmodule
